// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 once at start, then one C/D rotation plus PC-2
// per round, emitting 16 subkeys over valid/ready in forward or reverse order.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17,  9,
                                 1, 58, 50, 42, 34, 26, 18,
                                10,  2, 59, 51, 43, 35, 27,
                                19, 11,  3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15,
                                 7, 62, 54, 46, 38, 30, 22,
                                14,  6, 61, 53, 45, 37, 29,
                                21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{14, 17, 11, 24,  1,  5,
                                 3, 28, 15,  6, 21, 10,
                                23, 19, 12,  4, 26,  8,
                                16,  7, 27, 20, 13,  2,
                                41, 52, 31, 37, 47, 55,
                                30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53,
                                46, 42, 50, 36, 29, 32};

  // Table entries are FIPS bit numbers (1 = MSB); shifting in builds MSB first.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1_T[i]);
      r   = {r[54:0], k[idx]};
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  idx;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2_T[i]);
      r   = {r[46:0], cd[idx]};
    end
    return r;
  endfunction

  // Shift count for 1-based round index 1..16.
  function automatic logic [1:0] shift_amt(input logic [4:0] idx);
    case (idx)
      5'd1, 5'd2, 5'd9, 5'd16: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state, state_next;
  logic [27:0] c, d, c_next, d_next;
  logic        dec;
  logic        load, advance, finish;
  logic [55:0] cd0;
  logic [1:0]  enc_sh, dec_sh;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: if (subkey_ready) begin
        if (round == 4'd15) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Encrypt applies SHIFT[r+2] going forward; decrypt undoes SHIFT[16-r] going back.
  assign cd0    = pc1(key);
  assign enc_sh = shift_amt({1'b0, round} + 5'd2);
  assign dec_sh = shift_amt(5'd16 - {1'b0, round});

  always_comb begin
    c_next = c;
    d_next = d;
    if (load) begin
      c_next = decrypt ? cd0[55:28] : rol28(cd0[55:28], 2'd1);
      d_next = decrypt ? cd0[27:0]  : rol28(cd0[27:0], 2'd1);
    end else if (advance) begin
      c_next = dec ? ror28(c, dec_sh) : rol28(c, enc_sh);
      d_next = dec ? ror28(d, dec_sh) : rol28(d, enc_sh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c     <= '0;
      d     <= '0;
      round <= '0;
      dec   <= 1'b0;
      done  <= 1'b0;
    end else begin
      c    <= c_next;
      d    <= d_next;
      done <= finish;
      if (load) begin
        round <= '0;
        dec   <= decrypt;
      end else if (advance) begin
        round <= round + 4'd1;
      end
    end
  end

  assign subkey       = pc2({c, d});
  assign busy         = (state == RUN);
  assign subkey_valid = (state == RUN);

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: directed DES keys, expected subkeys queued
// at issue time and popped by an independent monitor on every accepted transfer.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready = 1'b1;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  des_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .decrypt(decrypt),
    .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  r;
    logic [47:0] k;
  } exp_t;

  // Worked-example schedule for key 133457799BBCDFF1, K1..K16.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123457799BBCDFF0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_acc_cyc = -100;
  bit   bp_mode = 1'b0;
  exp_t exp_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      subkey_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on every accepted transfer, checks hold-stability under backpressure
  initial begin
    exp_t        e;
    bit          hold_pending;
    logic [47:0] hold_k;
    logic [3:0]  hold_r;
    hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!subkey_valid) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_subkey", subkey, hold_k);
          check("hold_round", round, hold_r);
          hold_pending = 1'b0;
        end
        if (subkey_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_subkey", subkey, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("subkey_r%0d", e.r), subkey, e.k);
            check($sformatf("round_r%0d", e.r), round, e.r);
            if (round == 4'd15) last_acc_cyc = cyc;
          end
        end else begin
          hold_pending = 1'b1;
          hold_k = subkey;
          hold_r = round;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_accept", cyc - last_acc_cyc, 1);
      end
    end
  end

  task automatic push_exp(input bit dec);
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{r: 4'(i), k: (dec ? KS[15 - i] : KS[i])});
  endtask

  // Key and decrypt are scrambled after the start edge; the DUT must ignore them.
  task automatic start_sched(input logic [63:0] k, input bit dec);
    @(posedge clk);
    #1;
    key = k;
    decrypt = dec;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = {$urandom, $urandom};
    decrypt = ~dec;
    check("valid_after_start", subkey_valid, 1);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (subkey_valid && round == r) got = 1'b1;
    end
    if (!got) check("wait_round_timeout", 0, 1);
  endtask

  task automatic run(input logic [63:0] k, input bit dec, input bit bp, input string tag);
    int d0, n;
    d0 = done_cnt;
    push_exp(dec);
    bp_mode = bp;
    start_sched(k, dec);
    wait_done(n);
    if (!bp) check({tag, "_cycles"}, n, 16);
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_idle_valid"}, subkey_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int d0, n;
    #1;
    check("rst_valid", subkey_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_round", round, 0);
    check("rst_subkey", subkey, 0);
    #20 rst_n = 1'b1;

    run(KEY_A, 1'b0, 1'b0, "enc");
    run(KEY_A, 1'b1, 1'b0, "dec");
    run(KEY_A, 1'b0, 1'b1, "bp_enc");
    run(KEY_A, 1'b1, 1'b1, "bp_dec");
    run(KEY_P, 1'b0, 1'b0, "parity");

    // start with a different key mid-schedule must be ignored
    d0 = done_cnt;
    push_exp(1'b0);
    start_sched(KEY_A, 1'b0);
    wait_round(4'd5);
    @(posedge clk);
    #1;
    key = 64'h0123456789ABCDEF;
    decrypt = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    repeat (3) @(posedge clk);
    #1;
    check("ignore_done_once", done_cnt - d0, 1);
    check("ignore_queue_empty", exp_q.size(), 0);

    // start on the done cycle begins a new schedule immediately
    d0 = done_cnt;
    push_exp(1'b0);
    start_sched(KEY_A, 1'b0);
    wait_done(n);
    push_exp(1'b1);
    key = KEY_A;
    decrypt = 1'b1;
    start = 1'b1;
    check("donecyc_busy_low", busy, 0);
    check("donecyc_valid_low", subkey_valid, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("donecyc_valid_rise", subkey_valid, 1);
    check("donecyc_round0", round, 0);
    wait_done(n);
    repeat (3) @(posedge clk);
    #1;
    check("donecyc_done_twice", done_cnt - d0, 2);
    check("donecyc_queue_empty", exp_q.size(), 0);

    // async reset at round 7
    d0 = done_cnt;
    push_exp(1'b0);
    start_sched(KEY_A, 1'b0);
    wait_round(4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", subkey_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_round", round, 0);
    check("arst_subkey", subkey, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt - d0, 0);
    run(KEY_A, 1'b0, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
